// File: rtl/brownout_seq.sv
// Brownout detector sequencer: power-up settle, armed event monitoring and
// a descending vtrip calibration sweep, all clocked on the detector oscillator.
//
// state       | meaning
// ------------+----------------------------------------------------------
// S_OFF       | detector disabled, all drive outputs idle
// S_SETTLE    | detector enabled, waiting out the settle window
// S_ARMED     | monitoring brout_filt, accepting cal_start / vtrip changes
// S_CAL_STEP  | apply next sweep code, reload the dwell timer
// S_CAL_DWELL | hold the sweep code and watch for a trip
module brownout_seq #(
    parameter int SETTLE_CYC = 64,
    parameter int DWELL_CYC  = 16,
    parameter int EVT_W      = 8
) (
    input  logic             osc_ck,
    input  logic             rsb,
    input  logic             cfg_ena,
    input  logic [2:0]       cfg_vtrip,
    input  logic [2:0]       cfg_otrip,
    input  logic             cal_start,
    input  logic             evt_clr,
    input  logic             brout_filt,
    output logic             ena,
    output logic [2:0]       vtrip,
    output logic [2:0]       otrip,
    output logic             force_rc_osc,
    output logic             force_short_oneshot,
    output logic             armed,
    output logic             cal_busy,
    output logic             cal_done,
    output logic             cal_fail,
    output logic [2:0]       cal_code,
    output logic             brownout_evt,
    output logic [EVT_W-1:0] evt_cnt
);

    localparam int CNT_MAX = (SETTLE_CYC > DWELL_CYC) ? SETTLE_CYC : DWELL_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX);

    typedef enum logic [2:0] {
        S_OFF,
        S_SETTLE,
        S_ARMED,
        S_CAL_STEP,
        S_CAL_DWELL
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         code_q, code_d;
    logic               trip_q, trip_d;
    logic               bs1_q, bs_q, bp_q;
    logic               ena_q, ena_d;
    logic [2:0]         vtrip_q, vtrip_d;
    logic [2:0]         otrip_q, otrip_d;
    logic               force_rc_osc_q, force_rc_osc_d;
    logic               force_short_q, force_short_d;
    logic               armed_q, armed_d;
    logic               cal_busy_q, cal_busy_d;
    logic               cal_done_q, cal_done_d;
    logic               cal_fail_q, cal_fail_d;
    logic [2:0]         cal_code_q, cal_code_d;
    logic               brownout_evt_q, brownout_evt_d;
    logic [EVT_W-1:0]   evt_cnt_q, evt_cnt_d;
    logic               rise;
    logic               trip_now;
    logic               in_cal;

    always_ff @(posedge osc_ck) begin
        if (!rsb) begin
            state_q        <= S_OFF;
            cnt_q          <= '0;
            code_q         <= '0;
            trip_q         <= 1'b0;
            bs1_q          <= 1'b0;
            bs_q           <= 1'b0;
            bp_q           <= 1'b0;
            ena_q          <= 1'b0;
            vtrip_q        <= '0;
            otrip_q        <= '0;
            force_rc_osc_q <= 1'b0;
            force_short_q  <= 1'b0;
            armed_q        <= 1'b0;
            cal_busy_q     <= 1'b0;
            cal_done_q     <= 1'b0;
            cal_fail_q     <= 1'b0;
            cal_code_q     <= '0;
            brownout_evt_q <= 1'b0;
            evt_cnt_q      <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            code_q         <= code_d;
            trip_q         <= trip_d;
            bs1_q          <= brout_filt;
            bs_q           <= bs1_q;
            bp_q           <= bs_q;
            ena_q          <= ena_d;
            vtrip_q        <= vtrip_d;
            otrip_q        <= otrip_d;
            force_rc_osc_q <= force_rc_osc_d;
            force_short_q  <= force_short_d;
            armed_q        <= armed_d;
            cal_busy_q     <= cal_busy_d;
            cal_done_q     <= cal_done_d;
            cal_fail_q     <= cal_fail_d;
            cal_code_q     <= cal_code_d;
            brownout_evt_q <= brownout_evt_d;
            evt_cnt_q      <= evt_cnt_d;
        end
    end

    // bs lags vtrip by the synchronizer depth, so the first dwell cycle still
    // reflects the previous code and is excluded from the trip decision.
    assign rise     = bs_q & ~bp_q;
    assign trip_now = trip_q | (bs_q & (cnt_q != CNT_W'(DWELL_CYC - 1)));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        code_d     = code_q;
        trip_d     = trip_q;
        cal_done_d = cal_done_q;
        cal_fail_d = cal_fail_q;
        cal_code_d = cal_code_q;

        if (!cfg_ena) begin
            state_d    = S_OFF;
            cal_done_d = 1'b0;
            cal_fail_d = 1'b0;
        end else begin
            case (state_q)
                S_OFF: begin
                    state_d = S_SETTLE;
                    cnt_d   = CNT_W'(SETTLE_CYC - 1);
                end
                S_SETTLE: begin
                    if (cnt_q == '0) state_d = S_ARMED;
                    else             cnt_d   = cnt_q - 1'b1;
                end
                S_ARMED: begin
                    // A calibration request wins over a simultaneous code change.
                    if (cal_start) begin
                        cal_done_d = 1'b0;
                        cal_fail_d = 1'b0;
                        code_d     = 3'd7;
                        state_d    = S_CAL_STEP;
                    end else if (cfg_vtrip != vtrip_q) begin
                        state_d = S_SETTLE;
                        cnt_d   = CNT_W'(SETTLE_CYC - 1);
                    end
                end
                S_CAL_STEP: begin
                    cnt_d   = CNT_W'(DWELL_CYC - 1);
                    trip_d  = 1'b0;
                    state_d = S_CAL_DWELL;
                end
                S_CAL_DWELL: begin
                    if (cnt_q == '0) begin
                        if (!trip_now) begin
                            cal_code_d = code_q;
                            cal_done_d = 1'b1;
                            state_d    = S_SETTLE;
                            cnt_d      = CNT_W'(SETTLE_CYC - 1);
                        end else if (code_q != 3'd0) begin
                            code_d  = code_q - 3'd1;
                            state_d = S_CAL_STEP;
                        end else begin
                            cal_code_d = 3'd0;
                            cal_fail_d = 1'b1;
                            cal_done_d = 1'b1;
                            state_d    = S_SETTLE;
                            cnt_d      = CNT_W'(SETTLE_CYC - 1);
                        end
                    end else begin
                        cnt_d  = cnt_q - 1'b1;
                        trip_d = trip_now;
                    end
                end
                default: state_d = S_OFF;
            endcase
        end
    end

    always_comb begin
        in_cal         = (state_d == S_CAL_STEP) || (state_d == S_CAL_DWELL);
        ena_d          = (state_d != S_OFF);
        force_rc_osc_d = (state_d == S_SETTLE) || in_cal;
        force_short_d  = in_cal;
        armed_d        = (state_d == S_ARMED);
        cal_busy_d     = in_cal;
        vtrip_d        = in_cal ? code_d : cfg_vtrip;
        otrip_d        = cfg_otrip;
        // Edges seen in the cycle the FSM leaves ARMED are dropped.
        brownout_evt_d = rise && (state_q == S_ARMED) && (state_d == S_ARMED);

        evt_cnt_d = evt_cnt_q;
        if (evt_clr)
            evt_cnt_d = brownout_evt_q ? EVT_W'(1) : '0;
        else if (brownout_evt_q && (evt_cnt_q != '1))
            evt_cnt_d = evt_cnt_q + EVT_W'(1);
    end

    assign ena                 = ena_q;
    assign vtrip               = vtrip_q;
    assign otrip               = otrip_q;
    assign force_rc_osc        = force_rc_osc_q;
    assign force_short_oneshot = force_short_q;
    assign armed               = armed_q;
    assign cal_busy            = cal_busy_q;
    assign cal_done            = cal_done_q;
    assign cal_fail            = cal_fail_q;
    assign cal_code            = cal_code_q;
    assign brownout_evt        = brownout_evt_q;
    assign evt_cnt             = evt_cnt_q;

endmodule
